// File: rtl/ff_mul.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ff_mul                                                          |
// | Purpose  : Bit-serial modular multiplier, tx_a = (rx_a * rx_b) mod rx_p.   |
// |            MSB-first interleaved double-and-add, one multiplier bit per    |
// |            clock. A reset pulse loads the operands and starts a multiply.  |
// |            tx_done is sticky from completion until the next reset.         |
// | Ports    : clk     - rising-edge clock                                     |
// |            reset   - synchronous active-high; also the start strobe        |
// |            rx_a    - multiplicand (must be < rx_p), sampled with reset     |
// |            rx_b    - multiplier (any value), sampled with reset            |
// |            rx_p    - modulus (1 < rx_p), sampled with reset                |
// |            tx_done - high from completion until the next reset            |
// |            tx_a    - product mod p, valid while tx_done is high           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ff_mul #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rx_a,
  input  logic [WIDTH-1:0] rx_b,
  input  logic [WIDTH-1:0] rx_p,
  output logic             tx_done,
  output logic [WIDTH-1:0] tx_a
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [0:0]    c_IDLE     = 1'b0;
  localparam logic [0:0]    c_RUN      = 1'b1;
  localparam logic [CW-1:0] c_CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] c_CNT_ZERO = '0;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_res;

  // All step arithmetic is one bit wider than the operands so that the
  // doubled accumulator and the sum never wrap before being compared to p.
  logic [WIDTH:0] w_p_ext;
  logic [WIDTH:0] w_d;
  logic [WIDTH:0] w_d_red;
  logic [WIDTH:0] w_s;
  logic [WIDTH:0] w_s_red;
  logic           w_bit;
  logic           w_unused_msb;

  assign w_p_ext = {1'b0, r_p};
  assign w_bit   = r_b[r_cnt[CW-2:0]];

  // acc < p and a < p keep each intermediate below 2p, so a single
  // conditional subtract is enough after both the double and the add.
  assign w_d     = {r_acc, 1'b0};
  assign w_d_red = (w_d >= w_p_ext) ? (w_d - w_p_ext) : w_d;
  assign w_s     = w_d_red + (w_bit ? {1'b0, r_a} : {(WIDTH + 1){1'b0}});
  assign w_s_red = (w_s >= w_p_ext) ? (w_s - w_p_ext) : w_s;

  // The reduced sum is below p, so its top bit carries no information.
  assign w_unused_msb = w_s_red[WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= rx_a;
      r_b     <= rx_b;
      r_p     <= rx_p;
      r_acc   <= '0;
      r_cnt   <= c_CNT_INIT;
      r_state <= c_RUN;
      r_done  <= 1'b0;
      r_res   <= '0;
    end else begin
      case (r_state)
        c_RUN: begin
          r_acc <= w_s_red[WIDTH-1:0];
          r_cnt <= r_cnt - c_CNT_ONE;
          if (r_cnt == c_CNT_ZERO) begin
            r_res   <= w_s_red[WIDTH-1:0];
            r_done  <= 1'b1;
            r_state <= c_IDLE;
          end
        end
        default: begin
          // IDLE: hold result and done flag, no step activity.
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign tx_done = r_done;
  assign tx_a    = r_res;

endmodule
`default_nettype wire

// File: tb/tb_ff_mul.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ff_mul                                                       |
// | Purpose  : Self-checking bench for ff_mul. Directed and random multiplies  |
// |            compared against an arithmetic (a*b) mod p reference, plus      |
// |            latency, reset-priority and input-isolation checks.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ff_mul;

  localparam int WIDTH = 256;
  localparam logic [WIDTH-1:0] c_SECP =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] rx_a;
  logic [WIDTH-1:0] rx_b;
  logic [WIDTH-1:0] rx_p;
  logic             tx_done;
  logic [WIDTH-1:0] tx_a;

  int n_vec;
  int n_err;

  ff_mul #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx_a    (rx_a),
    .rx_b    (rx_b),
    .rx_p    (rx_p),
    .tx_done (tx_done),
    .tx_a    (tx_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [WIDTH-1:0] ref_mulmod(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] p);
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] rem;
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    rem  = prod % {{WIDTH{1'b0}}, p};
    return rem[WIDTH-1:0];
  endfunction

  // Modular inverse by Fermat: a^(p-2) mod p (p prime).
  function automatic logic [WIDTH-1:0] ref_inv(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] p);
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] r;
    e = p - 2;
    r = 1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      r = ref_mulmod(r, r, p);
      if (e[i]) r = ref_mulmod(r, a, p);
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rnd256();
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH / 32; i++) r = {r[WIDTH-33:0], 32'($urandom())};
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reset sampled at the posedge between the two negedges (edge E0).
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] p);
    @(negedge clk);
    reset = 1'b1;
    rx_a  = a;
    rx_b  = b;
    rx_p  = p;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs edges E1..E_WIDTH; tx_done must rise exactly on E_WIDTH. Inputs are
  // scrambled mid-run to confirm the latched operands are used.
  task automatic wait_result(input string tag, input logic [WIDTH-1:0] exp);
    logic early;
    early = 1'b0;
    for (int k = 1; k <= WIDTH; k++) begin
      @(posedge clk);
      #1;
      if (k < WIDTH && tx_done !== 1'b0) early = 1'b1;
      if (k == 10) begin
        rx_a = rnd256();
        rx_b = rnd256();
        rx_p = rnd256();
      end
    end
    chk({tag, "_early_done"}, {{(WIDTH-1){1'b0}}, early}, '0);
    chk({tag, "_done"}, {{(WIDTH-1){1'b0}}, tx_done}, 1);
    chk({tag, "_result"}, tx_a, exp);
  endtask

  task automatic run_mul(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] p);
    start_op(a, b, p);
    wait_result(tag, ref_mulmod(a, b, p));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] inv;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    rx_a  = '0;
    rx_b  = '0;
    rx_p  = '0;

    // Reset values right after the first reset edge.
    start_op(3, 5, 7);
    chk("rst_done", {{(WIDTH-1){1'b0}}, tx_done}, '0);
    chk("rst_txa", tx_a, '0);
    wait_result("small_3x5_mod7", 1);

    // Done is sticky and the result holds while idle.
    repeat (20) @(posedge clk);
    #1;
    chk("sticky_done", {{(WIDTH-1){1'b0}}, tx_done}, 1);
    chk("sticky_txa", tx_a, 1);

    // secp256k1 corner cases.
    run_mul("secp_pm1_sq", c_SECP - 1, c_SECP - 1, c_SECP);
    run_mul("secp_zero", 0, c_SECP - 1, c_SECP);
    run_mul("secp_x1", 256'h1234, 1, c_SECP);
    run_mul("secp_b_allones", rnd256() % c_SECP, {WIDTH{1'b1}}, c_SECP);

    // Cross-check against a reference inverse: a * a^-1 == 1.
    for (int i = 0; i < 2; i++) begin
      a   = rnd256() % c_SECP;
      if (a == 0) a = 1;
      inv = ref_inv(a, c_SECP);
      start_op(a, inv, c_SECP);
      wait_result("inv_check", 1);
    end

    // Reset mid-operation: second reset sampled at edge E100.
    start_op(3, 5, 7);
    repeat (99) @(posedge clk);
    #1;
    chk("midop_not_done", {{(WIDTH-1){1'b0}}, tx_done}, '0);
    start_op(2, 3, 7);
    wait_result("midop_restart", 6);

    // Reset held for 5 edges; counting begins at the first low edge.
    @(negedge clk);
    reset = 1'b1;
    rx_a  = 4;
    rx_b  = 6;
    rx_p  = 11;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    wait_result("hold_reset", 2);

    // Reset coincident with the completion edge wins.
    start_op(3, 5, 7);
    repeat (WIDTH - 1) @(posedge clk);
    start_op(5, 6, 13);
    chk("rst_on_done_done", {{(WIDTH-1){1'b0}}, tx_done}, '0);
    chk("rst_on_done_txa", tx_a, '0);
    wait_result("rst_on_done_fresh", 4);

    // Random operands against the reference model.
    for (int i = 0; i < 120; i++) begin
      b = rnd256();
      a = rnd256() % c_SECP;
      if (i % 4 == 3) run_mul("rand_small_p", a % 1000, b, 1009);
      else            run_mul("rand_secp", a, b, c_SECP);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
